// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_pkg
//  Purpose  : Shared CPU front-end definitions: fetch FSM state encoding,
//             default reset PC / sequential step, and the immediate
//             extension-select codes understood by the extension unit.
//  Revision : 1.0  initial release
// ============================================================================
package pc_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_VALID  = 2'd1,
        S_HALTED = 2'd2
    } fetch_state_t;

    // Front-end defaults
    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam int          c_pc_step_default  = 4;

    // Extension-unit select codes applied to the raw 24-bit immediate
    localparam logic [1:0] c_ext_sel_sign24   = 2'd0;  // sign-extend imm[23:0]
    localparam logic [1:0] c_ext_sel_zero24   = 2'd1;  // zero-extend imm[23:0]
    localparam logic [1:0] c_ext_sel_sign16   = 2'd2;  // sign-extend imm[15:0]
    localparam logic [1:0] c_ext_sel_sign24w  = 2'd3;  // sign-extend, word-scaled

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_if
//  Purpose  : Bundle of the fetch unit's instruction-memory, decode and
//             redirect signals.
//  Ports    : master - fetch unit side (drives im_req/im_addr, IR outputs)
//             slave  - environment side (memory, decode, branch resolution)
//  Revision : 1.0  initial release
// ============================================================================
interface pc_fetch_if;
    // Instruction-memory request channel
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    // Decode channel
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic [23:0] imm_field;
    // Control-flow changes
    logic        redirect;
    logic [31:0] redir_pc;
    logic [31:0] ext_out;
    logic        halt;

    modport master (
        output im_req, im_addr, ir_valid, ir_out, ir_pc, imm_field,
        input  im_ack, im_rdata, ir_ready, redirect, redir_pc, ext_out, halt
    );

    modport slave (
        input  im_req, im_addr, ir_valid, ir_out, ir_pc, imm_field,
        output im_ack, im_rdata, ir_ready, redirect, redir_pc, ext_out, halt
    );
endinterface : pc_fetch_if
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch
//  Purpose  : Instruction fetch unit. Issues one memory request at a time,
//             latches the returned word into the instruction register, hands
//             it to decode, and follows taken branches/jumps (target =
//             redir_pc + ext_out). A redirect that arrives while a request is
//             in flight lets that request finish and throws its data away.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - pc_fetch_if.master (memory, decode, redirect, halt)
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default,
    parameter int          PC_STEP  = c_pc_step_default
) (
    input  wire logic      clk,
    input  wire logic      rst,
    pc_fetch_if.master     bus
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;        // next address to fetch
    logic [31:0]  r_im_addr;   // address presented to memory
    logic         r_drop;      // in-flight request must be discarded
    logic [31:0]  r_ir_out;
    logic [31:0]  r_ir_pc;

    logic [31:0]  w_target;
    logic [31:0]  w_pc_inc;

    // Both adders wrap silently modulo 2^32.
    assign w_target = bus.redir_pc + bus.ext_out;
    assign w_pc_inc = r_pc + 32'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_im_addr <= RESET_PC;
            r_drop    <= 1'b0;
            r_ir_out  <= 32'h0;
            r_ir_pc   <= 32'h0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.redirect) begin
                        r_pc <= w_target;
                        if (bus.im_ack) begin
                            // Returned word belongs to the old path; retarget now.
                            r_drop    <= 1'b0;
                            r_im_addr <= w_target;
                        end else begin
                            // Request already in flight: keep im_addr on the old
                            // address until it is acknowledged. A repeat redirect
                            // only moves r_pc.
                            r_drop    <= 1'b1;
                        end
                    end else if (bus.im_ack) begin
                        if (r_drop) begin
                            r_drop    <= 1'b0;
                            r_im_addr <= r_pc;
                        end else begin
                            r_ir_out  <= bus.im_rdata;
                            r_ir_pc   <= r_pc;
                            r_pc      <= w_pc_inc;
                            r_im_addr <= w_pc_inc;
                            r_state   <= S_VALID;
                        end
                    end
                end

                S_VALID: begin
                    // Redirect wins over both acceptance and halt: the held
                    // instruction is on the wrong path.
                    if (bus.redirect) begin
                        r_pc      <= w_target;
                        r_im_addr <= w_target;
                        r_state   <= S_FETCH;
                    end else if (bus.ir_ready) begin
                        r_state   <= bus.halt ? S_HALTED : S_FETCH;
                    end
                end

                S_HALTED: begin
                    // Only reset leaves this state.
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // im_req is gated by rst so no request is seen while reset is held, and
    // it rises as soon as reset is released.
    assign bus.im_req    = (r_state == S_FETCH) && !rst;
    assign bus.im_addr   = r_im_addr;
    assign bus.ir_valid  = (r_state == S_VALID);
    assign bus.ir_out    = r_ir_out;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.imm_field = r_ir_out[23:0];

endmodule : pc_fetch
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch
//  Purpose  : Self-checking bench for pc_fetch. A memory responder with
//             programmable latency returns a word derived from the address;
//             a program-flow model predicts the PC of every instruction decode
//             accepts (previous accepted PC + 4, or the latest redirect target).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          mem_lat  = 0;
    int          mem_cnt  = 0;
    bit          mem_rand = 1'b0;
    logic [31:0] exp_pc   = 32'h0;
    bit          m_halted = 1'b0;
    int          accepts  = 0;

    // Memory contents: a recognisable word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] hi;
        hi = 16'h1111 * (a[17:2] + 16'd1);
        return {hi, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory responder, evaluated once per cycle just after the rising edge.
    task automatic mem_update();
        if (bus.im_ack) begin
            bus.im_ack = 1'b0;
            mem_cnt    = 0;
        end
        if (rst || !bus.im_req) begin
            mem_cnt = 0;
        end else if (mem_cnt >= mem_lat) begin
            bus.im_ack   = 1'b1;
            bus.im_rdata = mem_word(bus.im_addr);
            if (mem_rand) mem_lat = $urandom_range(0, 3);
        end else begin
            mem_cnt++;
        end
    endtask

    // Program-flow model evaluated on the inputs of the ending cycle, then the
    // clock advances and the memory responds.
    task automatic tick();
        if (!rst && !m_halted) begin
            if (bus.redirect) begin
                exp_pc = bus.redir_pc + bus.ext_out;
            end else if (bus.ir_valid && bus.ir_ready) begin
                chk("accept_pc", bus.ir_pc, exp_pc);
                chk("accept_ir", bus.ir_out, mem_word(exp_pc));
                accepts++;
                exp_pc = exp_pc + 32'd4;
                if (bus.halt) m_halted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        mem_update();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        int          a0;
        int          w;

        bus.im_ack   = 1'b0;
        bus.im_rdata = 32'h0;
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redir_pc = 32'h0;
        bus.ext_out  = 32'h0;
        bus.halt     = 1'b0;

        // Reset state
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_im_req",   32'(bus.im_req),    32'd0);
        chk("rst_ir_valid", 32'(bus.ir_valid),  32'd0);
        chk("rst_ir_out",   bus.ir_out,         32'h0);
        chk("rst_ir_pc",    bus.ir_pc,          32'h0);
        chk("rst_imm",      32'(bus.imm_field), 32'h0);

        // Release; two zero-wait fetches
        exp_pc = 32'h0; m_halted = 1'b0;
        rst = 1'b0;
        #1;
        chk("rel_im_req",  32'(bus.im_req), 32'd1);
        chk("rel_im_addr", bus.im_addr,     32'h0);
        mem_lat = 0;
        mem_update();
        bus.ir_ready = 1'b1;
        tick();
        chk("f0_valid", 32'(bus.ir_valid),  32'd1);
        chk("f0_ir",    bus.ir_out,         32'h1111_0000);
        chk("f0_pc",    bus.ir_pc,          32'h0);
        chk("f0_imm",   32'(bus.imm_field), 32'h0011_0000);
        chk("f0_noreq", 32'(bus.im_req),    32'd0);
        tick();
        chk("f1_req",  32'(bus.im_req), 32'd1);
        chk("f1_addr", bus.im_addr,     32'h4);
        tick();
        chk("f1_pc",  bus.ir_pc,          32'h4);
        chk("f1_imm", 32'(bus.imm_field), 32'h0022_0004);

        // Decode stalls for 5 cycles
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ir",    bus.ir_out,        32'h2222_0004);
            chk("stall_pc",    bus.ir_pc,         32'h4);
            chk("stall_req",   32'(bus.im_req),   32'd0);
            chk("stall_valid", 32'(bus.ir_valid), 32'd1);
        end

        // Redirect in VALID with ir_ready high: held word discarded
        bus.redir_pc = 32'h40; bus.ext_out = 32'hFFFF_FFF8;
        bus.redirect = 1'b1;   bus.ir_ready = 1'b1;
        tick();
        bus.redirect = 1'b0;
        chk("rv_valid", 32'(bus.ir_valid), 32'd0);
        chk("rv_req",   32'(bus.im_req),   32'd1);
        chk("rv_addr",  bus.im_addr,       32'h38);
        tick();
        chk("rv_pc", bus.ir_pc, 32'h38);

        // Redirect in FETCH two cycles before a latency-3 ack
        mem_lat = 3;
        tick();                    // accept 0x38, request 0x3C starts
        tick();
        bus.redir_pc = 32'h100; bus.ext_out = 32'h20; bus.redirect = 1'b1;
        tick();
        bus.redirect = 1'b0;
        chk("rf_hold_addr", bus.im_addr,       32'h3C);
        chk("rf_hold_req",  32'(bus.im_req),   32'd1);
        chk("rf_valid0",    32'(bus.ir_valid), 32'd0);
        tick();
        chk("rf_ack_addr",  bus.im_addr,       32'h3C);
        mem_lat = 0;
        tick();
        chk("rf_drop_valid", 32'(bus.ir_valid), 32'd0);
        chk("rf_new_req",    32'(bus.im_req),   32'd1);
        chk("rf_new_addr",   bus.im_addr,       32'h120);
        tick();
        chk("rf_pc", bus.ir_pc,  32'h120);
        chk("rf_ir", bus.ir_out, mem_word(32'h120));

        // Sequential wrap from the top of the address space
        bus.redir_pc = 32'hFFFF_FFF8; bus.ext_out = 32'h4; bus.redirect = 1'b1;
        tick();
        bus.redirect = 1'b0;
        chk("wrap_addr0", bus.im_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc0", bus.ir_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", bus.im_addr, 32'h0);
        tick();
        chk("wrap_pc1", bus.ir_pc, 32'h0);

        // Throughput: one instruction per two cycles with zero-wait memory
        a0 = accepts;
        repeat (8) tick();
        chk("tput", 32'(accepts - a0), 32'd4);

        // Redirect beats halt in the same cycle
        bus.redir_pc = 32'h200; bus.ext_out = 32'h0;
        bus.redirect = 1'b1;    bus.halt = 1'b1;
        tick();
        bus.redirect = 1'b0; bus.halt = 1'b0;
        chk("prio_req",   32'(bus.im_req),   32'd1);
        chk("prio_addr",  bus.im_addr,       32'h200);
        chk("prio_valid", 32'(bus.ir_valid), 32'd0);

        // Randomized traffic against the program-flow model
        mem_rand = 1'b1;
        a0 = accepts;
        for (int i = 0; i < 1500; i++) begin
            bus.ir_ready = ($urandom_range(0, 9) < 7);
            bus.redirect = ($urandom_range(0, 9) == 0);
            tmp = $urandom();
            bus.redir_pc = tmp & 32'hFFFF_FFFC;
            tmp = $urandom();
            bus.ext_out  = tmp & 32'hFFFF_FFFC;
            tick();
        end
        bus.redirect = 1'b0;
        mem_rand = 1'b0;
        mem_lat  = 0;
        chk("rand_progress", 32'(accepts - a0 > 100), 32'd1);

        // Halt: wait (bounded) for a valid instruction, accept it with halt
        bus.ir_ready = 1'b0;
        w = 0;
        while (!bus.ir_valid && w < 20) begin
            tick();
            w++;
        end
        chk("halt_wait_valid", 32'(bus.ir_valid), 32'd1);
        bus.halt = 1'b1; bus.ir_ready = 1'b1;
        tick();
        bus.halt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.redirect = i[0];
            bus.redir_pc = 32'h300;
            bus.ext_out  = 32'h0;
            tick();
            chk("halted_req",   32'(bus.im_req),   32'd0);
            chk("halted_valid", 32'(bus.ir_valid), 32'd0);
        end
        bus.redirect = 1'b0;

        // Reset out of HALTED, then reset again in the middle of a fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        exp_pc = 32'h0; m_halted = 1'b0;
        chk("rst2_req",  32'(bus.im_req), 32'd1);
        chk("rst2_addr", bus.im_addr,     32'h0);
        mem_lat = 3;
        mem_update();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_req", 32'(bus.im_req), 32'd0);
        tick();
        tick();
        mem_lat = 0;
        rst = 1'b0;
        #1;
        exp_pc = 32'h0;
        chk("restart_req",  32'(bus.im_req), 32'd1);
        chk("restart_addr", bus.im_addr,     32'h0);
        mem_update();
        tick();
        chk("restart_valid", 32'(bus.ir_valid), 32'd1);
        chk("restart_pc",    bus.ir_pc,         32'h0);
        chk("restart_ir",    bus.ir_out,        mem_word(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_fetch
`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment in bytes.
REQ-003 SHALL use one clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have im_req  output  1  instruction-memory request, held until acknowledged.
REQ-006 SHALL have im_addr  output  32  fetch byte address, equal to the PC whenever im_req=1.
REQ-007 SHALL have im_ack  input  1  one-cycle memory acknowledge; im_rdata valid in the same cycle.
REQ-008 SHALL have im_rdata  input  32  fetched instruction word.
REQ-009 SHALL have ir_valid  output  1  instruction register holds a valid instruction for decode.
REQ-010 SHALL have ir_ready  input  1  decode accepts the instruction this cycle.
REQ-011 SHALL have ir_out  output  32  instruction register.
REQ-012 SHALL have ir_pc  output  32  address the instruction in ir_out was fetched from.
REQ-013 SHALL have imm_field  output  24  ir_out[23:0], the raw immediate sent to the extension unit.
REQ-014 SHALL have redirect  input  1  a branch or jump has resolved as taken.
REQ-015 SHALL have redir_pc  input  32  PC of the redirecting instruction.
REQ-016 SHALL have ext_out  input  32  extended offset returned by the extension unit.
REQ-017 SHALL have halt  input  1  stop fetching after the current instruction is accepted.

Function
REQ-018 SHALL implement FSM states FETCH, VALID, HALTED.
REQ-019 FETCH: im_req=1, im_addr=pc. On im_ack with no pending drop: ir_out<=im_rdata, ir_pc<=pc, pc<=pc+PC_STEP, go VALID.
REQ-020 VALID: ir_valid=1, im_req=0. On ir_ready&~halt go FETCH. On ir_ready&halt go HALTED. Otherwise hold ir_out/ir_pc unchanged.
REQ-021 HALTED: im_req=0, ir_valid=0. Leave only by reset.
REQ-022 Redirect target SHALL be redir_pc+ext_out, modulo 2^32; wrap past 32'hFFFF_FFFC is silent.
REQ-023 Redirect in VALID: pc<=target, ir_valid drops the next cycle, go FETCH. The held instruction is discarded even if ir_ready=1 in the same cycle.
REQ-024 Redirect in FETCH with im_ack in the same cycle: discard im_rdata, pc<=target, stay FETCH with the new address next cycle.
REQ-025 Redirect in FETCH without im_ack: pc<=target and set drop flag. im_req and im_addr SHALL stay on the old address until im_ack, because the request is already in flight. That ack's data is discarded, the flag clears, and FETCH continues at target.
REQ-026 A second redirect while drop is set SHALL overwrite pc only; one drop is sufficient.
REQ-027 Redirect SHALL take priority over halt in the same cycle. In HALTED, redirect is ignored.
REQ-028 Sequential pc increment SHALL wrap modulo 2^32.
REQ-029 imm_field SHALL be combinational from ir_out; all other outputs SHALL be registered or decoded from state only.
REQ-030 Minimum sustained throughput SHALL be one instruction per 2 cycles with zero-wait memory.

Reset
REQ-031 On rst: state=FETCH, pc=RESET_PC, drop=0, ir_valid=0, ir_out=0, ir_pc=0. im_req SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-032 Reset mid-request SHALL abandon the outstanding fetch; the memory is reset by the same rst.

Structure
REQ-033 FSM state encodings, PC_STEP and RESET_PC defaults SHALL live in the shared CPU package with the extension-select constants.
REQ-034 No sub-module is needed; the target adder SHALL be inline.

Verification
REQ-035 Reset release, zero-wait memory returning 32'h1111_0000 then 32'h2222_0004, ir_ready=1: im_addr 0 then 4; ir_pc 0 then 4; imm_field 24'h110000 then 24'h220004.
REQ-036 ir_ready=0 for 5 cycles in VALID: ir_out and ir_pc stable, im_req=0 throughout.
REQ-037 Redirect in VALID with redir_pc=32'h40 and ext_out=32'hFFFF_FFF8: next im_addr=32'h38 and the held instruction never accepted.
REQ-038 Redirect in FETCH 2 cycles before a 3-cycle-latency ack: old data dropped, ir_valid stays 0, next im_req carries the target address.
REQ-039 pc=32'hFFFF_FFFC fetch: next sequential im_addr=32'h0.
REQ-040 halt with ir_ready: HALTED, im_req=0 forever. rst asserted mid-FETCH: im_req=0 immediately and restart at RESET_PC.
